// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter sharing one single-cycle ALU and one response register.
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention (no round-robin pointer).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  output logic             req_ready_0,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [3:0]       req_op_0,
  input  logic             req_valid_1,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [3:0]       req_op_1,
  output logic             rsp_valid_0,
  input  logic             rsp_ready_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero
);

  logic             full;
  logic             owner;
  logic             grant_0;
  logic             grant_1;
  logic             drain;
  logic             room;
  logic             accept;
  logic             sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_y;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant_0 = req_valid_0;
    grant_1 = req_valid_1 & !req_valid_0;
  end
`else
  logic ptr;

  always_comb begin
    grant_0 = req_valid_0 & (!req_valid_1 | !ptr);
    grant_1 = req_valid_1 & (!req_valid_0 | ptr);
  end

  // Pointer flips to the other port after every transfer so contention alternates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= !sel;
    end
  end
`endif

  // Draining the owner's response frees the register for a new accept in the same cycle.
  assign drain       = full & (owner ? rsp_ready_1 : rsp_ready_0);
  assign room        = !full | drain;
  assign req_ready_0 = rst_n & grant_0 & room;
  assign req_ready_1 = rst_n & grant_1 & room;
  assign accept      = (req_valid_0 & req_ready_0) | (req_valid_1 & req_ready_1);
  assign sel         = req_valid_1 & req_ready_1;

  assign alu_a  = sel ? req_a_1  : req_a_0;
  assign alu_b  = sel ? req_b_1  : req_b_0;
  assign alu_op = sel ? req_op_1 : req_op_0;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      4'b0000: alu_y = alu_a & alu_b;
      4'b0001: alu_y = alu_a | alu_b;
      4'b0010: alu_y = alu_a + alu_b;
      4'b0110: alu_y = alu_a - alu_b;
      4'b1100: alu_y = ~(alu_a | alu_b);
      default: alu_y = '0;
    endcase
  end

  // Result and zero flag only change on accept, so they hold through a plain drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= 1'b0;
      owner      <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (accept) begin
      full       <= 1'b1;
      owner      <= sel;
      rsp_result <= alu_y;
      rsp_zero   <= (alu_y == '0);
    end else if (drain) begin
      full       <= 1'b0;
    end
  end

  assign rsp_valid_0 = full & !owner;
  assign rsp_valid_1 = full & owner;

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 32, operand/result width in bits.
REQ-002 The block SHALL have these ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  asynchronous, active-low reset
  req_valid_0 / req_valid_1  in  1  requester 0/1 has an operation
  req_ready_0 / req_ready_1  out  1  requester 0/1 operation accepted this cycle
  req_a_0 / req_a_1  in  WIDTH  operand a
  req_b_0 / req_b_1  in  WIDTH  operand b
  req_op_0 / req_op_1  in  4  ALU opcode
  rsp_valid_0 / rsp_valid_1  out  1  result for requester 0/1 available
  rsp_ready_0 / rsp_ready_1  in  1  requester 0/1 takes result
  rsp_result  out  WIDTH  shared result bus, valid with the asserted rsp_valid_x
  rsp_zero  out  1  shared flag, 1 when rsp_result == 0
REQ-003 The clock SHALL be clk, and reset SHALL be rst_n: asynchronous, active-low.

Function
REQ-004 Opcodes SHALL be: 0000 a&b, 0001 a|b, 0010 a+b (modulo 2^WIDTH), 0110 a-b (modulo 2^WIDTH), 1100 ~(a|b); any other opcode -> result 0.
REQ-005 A request on port x SHALL transfer when req_valid_x & req_ready_x are both high on a rising edge.
REQ-006 The block SHALL hold one response register: full flag, owner id, result, zero.
REQ-007 req_ready_x SHALL be combinational: grant_x & (!full | (rsp_valid_owner & rsp_ready_owner)), so a drain and a new accept can happen in the same cycle.
REQ-008 Grant, only one valid: that port is granted.
REQ-009 Grant, both valid: port given by round-robin pointer ptr.
REQ-010 Grant, none valid: no grant, ready low.
REQ-011 After a transfer from port g, ptr SHALL become !g; otherwise ptr SHALL hold.
REQ-012 Latency SHALL be 1 cycle: an op accepted at edge N is visible on rsp_* after edge N; throughput is 1 op/cycle when the owner's rsp_ready stays high.
REQ-013 rsp_valid_x SHALL equal full & (owner == x); at most one rsp_valid is high at any time.
REQ-014 While full and not drained, rsp_result, rsp_zero and owner SHALL hold stable, and both req_ready SHALL be 0.
REQ-015 Drain without a new accept SHALL clear full; rsp_result and rsp_zero hold their last value.
REQ-016 rsp_zero SHALL be computed from the registered result: unknown opcode gives result 0, zero 1.
REQ-017 Requesters hold their inputs stable while valid and not ready; the block SHALL NOT require that a non-granted requester deassert.

Reset
REQ-018 On rst_n low, immediately and regardless of clk: full=0, owner=0, ptr=0, rsp_result=0, rsp_zero=0; both rsp_valid and both req_ready SHALL be 0.
REQ-019 Reset mid-operation SHALL discard any pending response with no partial delivery; operation resumes on the first rising edge after rst_n is high.

Configuration
REQ-020 Macro ALU_ARB_FIXED_PRIO_EN, defined: the both-valid case SHALL always grant port 0, and ptr SHALL be removed.
REQ-021 Macro ALU_ARB_FIXED_PRIO_EN, undefined: round-robin SHALL apply per REQ-009 and REQ-011.

Verification
REQ-022 Port0 op 0010, a=5, b=7, rsp_ready_0=1 -> next cycle rsp_valid_0=1, rsp_result=12, rsp_zero=0, rsp_valid_1=0.
REQ-023 Both ports valid every cycle, both rsp_ready=1 -> accepts alternate 0,1,0,1 starting with 0 after reset, one per cycle.
REQ-024 Port1 op 0110, 9-9 -> rsp_result=0, rsp_zero=1. Op 1100 with 0,0 -> 0xFFFFFFFF. Op 0000 0xF0F0,0x0FF0 -> 0x00F0. Op 0111 -> 0, zero 1.
REQ-025 Port0 result pending with rsp_ready_0=0 for 3 cycles, port1 valid -> req_ready_1=0 and rsp_result stable throughout. When rsp_ready_0 rises, port1 is accepted in that same cycle.
REQ-026 rst_n dropped while rsp_valid_1=1 -> rsp_valid_1=0 without a clock edge. After release, both valid -> port 0 granted first.
REQ-027 With ALU_ARB_FIXED_PRIO_EN defined, both valid continuously -> only port 0 is accepted for 10 cycles. Port 1 is accepted in the first cycle port 0 deasserts.
